serial_eeprom_9346: RTL and testbench
=====================================

Name: serial_eeprom_9346

Overview:
- Cycle-based emulation of a 93C46-family Microwire serial EEPROM (default x8 organisation, 128 bytes).
- Used as the game-settings EEPROM in arcade cores.
- The serial pins (scs/sclk/sdi/sdo) are oversampled on the system clock.
- A read-only dump port exposes memory contents for save/inspection.

Parameters:
- AW, 7: memory address width; depth = 2**AW words.
- DW, 8: data word width (8 or 16).
- CW, 7: width of the address field in the serial command frame. Must be ≥ AW. Extra MSBs are ignored, and the low AW bits select the word.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  serial clock from host; sampled by clk.
- sdi  in  1  serial data in.
- sdo  out  1  serial data out.
- scs  in  1  chip select, active high.
- dump_addr  in  AW  dump read address.
- dump_dout  out  DW  word at dump_addr, registered on clk (1-cycle latency).

Behaviour:
- Sampling:
  - sclk is registered on clk; a rising edge is detected when the registered value is 0 and the current sclk is 1.
  - sdi and scs are sampled at that clk edge.
  - The host guarantees sclk high/low phases of at least 2 clk cycles each.
- Reset (rst=0):
  - FSM goes to IDLE; write-enable flag is cleared (writes disabled); sdo=1; shift registers are cleared.
  - Memory contents are not affected by reset.
  - Power-up memory contents are all ones.
- scs=0 at any time: FSM returns to IDLE and sdo=1. Any partially shifted command is discarded without modifying memory.
- Frame format, on sclk rising edges while scs=1:
  - START: wait for sdi=1 (leading zeros are ignored).
  - OP: 2 opcode bits, MSB first.
  - ADDR: CW address bits, MSB first.
  - Then per opcode:
    - READ (10): immediately after the last address bit, sdo=0 (dummy bit). On each following sclk rising edge, sdo presents the next data bit, MSB first, DW bits. After the LSB, the address increments (wrapping 2**AW-1 → 0) and the next word streams out until scs falls.
    - WRITE (01): shift DW data bits. On the last bit, if write-enabled, mem[addr] ← data.
    - ERASE (11): on the last address bit, if write-enabled, mem[addr] ← all ones.
    - 00 (extended), decoded from the top 2 bits of the address field:
      - 11 = EWEN: set the write-enable flag.
      - 00 = EWDS: clear the write-enable flag.
      - 10 = ERAL: if enabled, all words ← all ones.
      - 01 = WRAL: shift DW data bits; if enabled, all words ← data.
  - After a completed non-READ command, ignore further bits until scs falls.
- ERAL/WRAL:
  - May sequence through all addresses, one per clk (2**AW cycles).
  - Must finish before the next command's first write opportunity.
  - Busy time is reported as sdo=0 while scs=1, otherwise sdo=1 (ready).
- Write timing: single-word writes take effect within 1 clk of the last bit; no busy period.
- Dump port:
  - Independent read of the same memory; a true dual-port RAM is allowed.
  - A simultaneous serial write to the same address returns either old or new data; the new data must be visible the following cycle.

Decomposition:
- Package serial_eeprom_9346_pkg holds:
  - opcode constants OP_READ=2'b10, OP_WRITE=2'b01, OP_ERASE=2'b11, OP_EXT=2'b00;
  - extended sub-codes EXT_EWEN=2'b11, EXT_EWDS=2'b00, EXT_ERAL=2'b10, EXT_WRAL=2'b01;
  - the FSM state enum IDLE, OP, ADDR, DATA_IN, READ_OUT, BULK, DONE.
- One sub-module: serial_eeprom_9346_ram, a 2**AW×DW dual-port RAM.
  - Port A: read/write, used by the FSM.
  - Port B: read-only dump.
  - Initialised to all ones.

Test Plan:
- After reset (writes disabled), issue WRITE addr 0x05 data 0x3C, then drop scs → dump_addr=5 reads 0xFF.
- Issue EWEN, then WRITE 0x05 0x3C → dump addr 5 = 0x3C; all other addresses stay 0xFF.
- READ addr 0x05 while sampling sdo on sclk falling edges → bits 0,0,0,1,1,1,1,0,0 (dummy 0 then 0x3C), and sdo=1 after scs drops.
- EWEN; WRAL 0xA5 → all 128 dump words = 0xA5. Then ERAL → all 0xFF. Then ERASE 0x10 after WRITE 0x10 0x77 → 0xFF.
- scs dropped after 4 data bits of WRITE 0x20 0x55 → mem[0x20] unchanged (0xFF). The next full command executes normally.
- Write 0x11 to addr 0x7F and 0x22 to addr 0x00; READ 0x7F for 16 bits → 0x11 then 0x22 (sequential read wraps).

Source files
------------

// File: rtl/serial_eeprom_9346_pkg.sv
// Shared opcodes, extended sub-codes and FSM state type for the 93C46-style
// Microwire EEPROM emulation.
package serial_eeprom_9346_pkg;

   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_ERASE = 2'b11;
   localparam logic [1:0] OP_EXT   = 2'b00;

   localparam logic [1:0] EXT_EWEN = 2'b11;
   localparam logic [1:0] EXT_EWDS = 2'b00;
   localparam logic [1:0] EXT_ERAL = 2'b10;
   localparam logic [1:0] EXT_WRAL = 2'b01;

   typedef enum logic [2:0] {
      IDLE,
      OP,
      ADDR,
      DATA_IN,
      READ_OUT,
      BULK,
      DONE
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/serial_eeprom_9346_if.sv
// Serial pins plus dump port of the EEPROM; master = host side, slave = EEPROM.
interface serial_eeprom_9346_if #(
   parameter int AW = 7,
   parameter int DW = 8
);
   logic          sclk;
   logic          sdi;
   logic          scs;
   logic          sdo;
   logic [AW-1:0] dump_addr;
   logic [DW-1:0] dump_dout;

   modport master (
      output sclk, sdi, scs, dump_addr,
      input  sdo, dump_dout
   );

   modport slave (
      input  sclk, sdi, scs, dump_addr,
      output sdo, dump_dout
   );
endinterface

// File: rtl/serial_eeprom_9346_ram.sv
// Dual-port word RAM: port A read/write for the command FSM, port B read-only
// dump. Both reads are registered; contents power up as all ones.
module serial_eeprom_9346_ram #(
   parameter int AW = 7,
   parameter int DW = 8
) (
   input  logic          i_clk,
   input  logic          i_a_we,
   input  logic [AW-1:0] i_a_addr,
   input  logic [DW-1:0] i_a_din,
   output logic [DW-1:0] o_a_dout,
   input  logic [AW-1:0] i_b_addr,
   output logic [DW-1:0] o_b_dout
);
   localparam int DEPTH = 1 << AW;

   // Erased EEPROM cells read as ones, so the array starts there.
   logic [DW-1:0] r_mem [0:DEPTH-1] = '{default: {DW{1'b1}}};
   logic [DW-1:0] r_a_q;
   logic [DW-1:0] r_b_q;

   always_ff @(posedge i_clk) begin
      if (i_a_we)
         r_mem[i_a_addr] <= i_a_din;
      r_a_q <= r_mem[i_a_addr];
   end

   always_ff @(posedge i_clk) begin
      r_b_q <= r_mem[i_b_addr];
   end

   assign o_a_dout = r_a_q;
   assign o_b_dout = r_b_q;
endmodule

// File: rtl/serial_eeprom_9346.sv
// 93C46-family Microwire EEPROM emulation: serial pins oversampled on i_clk,
// command FSM driving a dual-port RAM, plus a registered dump read port.
module serial_eeprom_9346
   import serial_eeprom_9346_pkg::*;
#(
   parameter int AW = 7,
   parameter int DW = 8,
   parameter int CW = 7
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   serial_eeprom_9346_if.slave  bus
);
   localparam int CNT_W = $clog2(max_int(max_int(CW, DW), 2));
   localparam int BW    = $clog2(DW);

   state_t          r_state;
   state_t          w_state;
   logic            r_sclk_q;
   logic            w_rise;
   logic [1:0]      r_op,        w_op;
   logic [CW-1:0]   r_addr,      w_addr;
   logic [CW-1:0]   w_addr_full;
   logic [DW-2:0]   r_data,      w_data_sh;
   logic [DW-1:0]   w_data_full;
   logic [CNT_W-1:0] r_cnt,      w_cnt;
   logic            r_we_en,     w_we_en;
   logic            r_sdo,       w_sdo;
   logic [AW-1:0]   r_rd_addr,   w_rd_addr;
   logic [AW-1:0]   r_bulk_addr, w_bulk_addr;
   logic [DW-1:0]   r_bulk_data, w_bulk_data;

   logic            w_ram_we;
   logic [AW-1:0]   w_ram_addr;
   logic [DW-1:0]   w_ram_din;
   logic [DW-1:0]   w_ram_q;
   logic [DW-1:0]   w_dump_dout;

   assign w_rise = ~r_sclk_q & bus.sclk;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_sclk_q    <= 1'b0;
         r_op        <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_cnt       <= '0;
         r_we_en     <= 1'b0;
         r_sdo       <= 1'b1;
         r_rd_addr   <= '0;
         r_bulk_addr <= '0;
         r_bulk_data <= '0;
      end else begin
         r_state     <= w_state;
         r_sclk_q    <= bus.sclk;
         r_op        <= w_op;
         r_addr      <= w_addr;
         r_data      <= w_data_sh;
         r_cnt       <= w_cnt;
         r_we_en     <= w_we_en;
         r_sdo       <= w_sdo;
         r_rd_addr   <= w_rd_addr;
         r_bulk_addr <= w_bulk_addr;
         r_bulk_data <= w_bulk_data;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_op        = r_op;
      w_addr      = r_addr;
      w_data_sh   = r_data;
      w_cnt       = r_cnt;
      w_we_en     = r_we_en;
      w_sdo       = r_sdo;
      w_rd_addr   = r_rd_addr;
      w_bulk_addr = r_bulk_addr;
      w_bulk_data = r_bulk_data;
      w_ram_we    = 1'b0;
      w_ram_addr  = r_rd_addr;
      w_ram_din   = r_bulk_data;
      w_addr_full = {r_addr[CW-2:0], bus.sdi};
      w_data_full = {r_data, bus.sdi};

      // A bulk sweep runs to completion even if the host releases scs.
      if (r_state == BULK) begin
         w_ram_we    = 1'b1;
         w_ram_addr  = r_bulk_addr;
         w_bulk_addr = r_bulk_addr + AW'(1);
         if (r_bulk_addr == {AW{1'b1}})
            w_state = bus.scs ? DONE : IDLE;
      end else if (!bus.scs) begin
         w_state   = IDLE;
         w_op      = '0;
         w_addr    = '0;
         w_data_sh = '0;
         w_cnt     = '0;
         w_sdo     = 1'b1;
      end else if (w_rise) begin
         case (r_state)
            IDLE: begin
               if (bus.sdi) begin
                  w_state = OP;
                  w_cnt   = '0;
               end
            end
            OP: begin
               w_op = {r_op[0], bus.sdi};
               if (r_cnt == CNT_W'(1)) begin
                  w_state = ADDR;
                  w_cnt   = '0;
               end else begin
                  w_cnt = r_cnt + CNT_W'(1);
               end
            end
            ADDR: begin
               w_addr = w_addr_full;
               w_cnt  = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(CW-1)) begin
                  w_cnt   = '0;
                  w_state = DONE;
                  case (r_op)
                     OP_READ: begin
                        w_state   = READ_OUT;
                        w_rd_addr = w_addr_full[AW-1:0];
                        w_sdo     = 1'b0;
                     end
                     OP_WRITE: w_state = DATA_IN;
                     OP_ERASE: begin
                        if (r_we_en) begin
                           w_ram_we   = 1'b1;
                           w_ram_addr = w_addr_full[AW-1:0];
                           w_ram_din  = {DW{1'b1}};
                        end
                     end
                     default: begin
                        case (w_addr_full[CW-1 -: 2])
                           EXT_EWEN: w_we_en = 1'b1;
                           EXT_EWDS: w_we_en = 1'b0;
                           EXT_ERAL: begin
                              if (r_we_en) begin
                                 w_state     = BULK;
                                 w_bulk_addr = '0;
                                 w_bulk_data = {DW{1'b1}};
                              end
                           end
                           default: w_state = DATA_IN;
                        endcase
                     end
                  endcase
               end
            end
            DATA_IN: begin
               w_data_sh = w_data_full[DW-2:0];
               w_cnt     = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(DW-1)) begin
                  w_cnt   = '0;
                  w_state = DONE;
                  if (r_op == OP_WRITE) begin
                     if (r_we_en) begin
                        w_ram_we   = 1'b1;
                        w_ram_addr = r_addr[AW-1:0];
                        w_ram_din  = w_data_full;
                     end
                  end else if (r_we_en) begin
                     w_state     = BULK;
                     w_bulk_addr = '0;
                     w_bulk_data = w_data_full;
                  end
               end
            end
            READ_OUT: begin
               // RAM output already reflects r_rd_addr: sclk phases are several clk long.
               w_sdo = w_ram_q[BW'(DW-1) - r_cnt[BW-1:0]];
               if (r_cnt == CNT_W'(DW-1)) begin
                  w_cnt     = '0;
                  w_rd_addr = r_rd_addr + AW'(1);
               end else begin
                  w_cnt = r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sdo = ~bus.scs | ((r_state != BULK) & r_sdo);

   serial_eeprom_9346_ram #(
      .AW (AW),
      .DW (DW)
   ) u_ram (
      .i_clk    (i_clk),
      .i_a_we   (w_ram_we),
      .i_a_addr (w_ram_addr),
      .i_a_din  (w_ram_din),
      .o_a_dout (w_ram_q),
      .i_b_addr (bus.dump_addr),
      .o_b_dout (w_dump_dout)
   );

   assign bus.dump_dout = w_dump_dout;
endmodule

// File: tb/tb_serial_eeprom_9346.sv
// Directed bench for serial_eeprom_9346: drives Microwire frames, checks the
// dump port and the serial read stream against hand-computed values.
module tb_serial_eeprom_9346;
   import serial_eeprom_9346_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   serial_eeprom_9346_if #(.AW(7), .DW(8)) bus ();

   serial_eeprom_9346 #(.AW(7), .DW(8), .CW(7)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, output logic so);
      bus.sdi = b;
      tick(4);
      bus.sclk = 1'b1;
      tick(4);
      so = bus.sdo;
      bus.sclk = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] v, input int n);
      logic so;
      for (int i = n - 1; i >= 0; i--) send_bit(v[i], so);
   endtask

   task automatic cs_begin();
      tick(1);
      bus.scs = 1'b1;
      tick(2);
   endtask

   task automatic cs_end();
      bus.scs = 1'b0;
      bus.sdi = 1'b0;
      tick(4);
   endtask

   // Leading zero before the start bit exercises start-bit hunting.
   task automatic cmd(input logic [1:0] op, input logic [6:0] a);
      cs_begin();
      send_bits(16'h0001, 2);
      send_bits({14'd0, op}, 2);
      send_bits({9'd0, a}, 7);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d);
      cmd(OP_WRITE, a);
      send_bits({8'd0, d}, 8);
      cs_end();
   endtask

   task automatic do_ext(input logic [1:0] sub);
      cmd(OP_EXT, {sub, 5'd0});
      cs_end();
   endtask

   task automatic dump_rd(input logic [6:0] a, output logic [7:0] d);
      bus.dump_addr = a;
      tick(1);
      d = bus.dump_dout;
   endtask

   task automatic read_stream(input logic [6:0] a, input int nbits, output logic [16:0] got);
      logic so;
      cs_begin();
      send_bits(16'h0001, 1);
      send_bits({14'd0, OP_READ}, 2);
      send_bits({10'd0, a[6:1]}, 6);
      send_bit(a[0], so);
      got = {16'd0, so};
      for (int i = 0; i < nbits; i++) begin
         send_bit(1'b0, so);
         got = {got[15:0], so};
      end
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (bus.sdo !== 1'b1 && n < 400) begin
         tick(1);
         n++;
      end
      checks++;
      if (bus.sdo !== 1'b1) begin
         failures++;
         $display("FAIL %s ready: sdo=%b after %0d cycles, required 1", name, bus.sdo, n);
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      bus.sclk = 1'b0; bus.sdi = 1'b0; bus.scs = 1'b0; bus.dump_addr = '0;
      rst_n = 1'b0;
      tick(3);
      checks++;
      if (bus.sdo !== 1'b1) begin
         failures++; $display("FAIL reset_sdo: got %b required 1", bus.sdo);
      end
      rst_n = 1'b1;
      tick(2);
      dump_rd(7'h05, d);
      checks++;
      if (d !== 8'hFF) begin
         failures++; $display("FAIL reset_mem5: got %h required ff", d);
      end
      dump_rd(7'h7F, d);
      checks++;
      if (d !== 8'hFF) begin
         failures++; $display("FAIL reset_mem7f: got %h required ff", d);
      end
      cs_begin();
      checks++;
      if (bus.sdo !== 1'b1) begin
         failures++; $display("FAIL idle_sdo: got %b required 1", bus.sdo);
      end
      cs_end();
   endtask

   task automatic test_write_disabled();
      logic [7:0] d;
      do_write(7'h05, 8'h3C);
      dump_rd(7'h05, d);
      checks++;
      if (d !== 8'hFF) begin
         failures++; $display("FAIL write_disabled: got %h required ff", d);
      end
   endtask

   task automatic test_write_enabled();
      logic [7:0] d;
      logic [7:0] exp;
      do_ext(EXT_EWEN);
      do_write(7'h05, 8'h3C);
      for (int a = 0; a < 128; a++) begin
         dump_rd(7'(a), d);
         exp = (a == 5) ? 8'h3C : 8'hFF;
         checks++;
         if (d !== exp) begin
            failures++; $display("FAIL write_enabled[%0d]: got %h required %h", a, d, exp);
         end
      end
   endtask

   task automatic test_read();
      logic [16:0] got;
      read_stream(7'h05, 8, got);
      checks++;
      if (got[8:0] !== 9'b000111100) begin
         failures++; $display("FAIL read_05: got %b required 000111100", got[8:0]);
      end
      cs_end();
      checks++;
      if (bus.sdo !== 1'b1) begin
         failures++; $display("FAIL read_sdo_release: got %b required 1", bus.sdo);
      end
   endtask

   task automatic test_bulk();
      logic [7:0] d;
      logic       so;
      do_ext(EXT_EWEN);
      cmd(OP_EXT, {EXT_WRAL, 5'd0});
      send_bits(16'h0052, 7);
      send_bit(1'b1, so);
      checks++;
      if (so !== 1'b0) begin
         failures++; $display("FAIL wral_busy: got %b required 0", so);
      end
      wait_ready("wral");
      cs_end();
      for (int a = 0; a < 128; a++) begin
         dump_rd(7'(a), d);
         checks++;
         if (d !== 8'hA5) begin
            failures++; $display("FAIL wral[%0d]: got %h required a5", a, d);
         end
      end
      cmd(OP_EXT, {EXT_ERAL, 5'd0});
      checks++;
      if (bus.sdo !== 1'b0) begin
         failures++; $display("FAIL eral_busy: got %b required 0", bus.sdo);
      end
      wait_ready("eral");
      cs_end();
      for (int a = 0; a < 128; a++) begin
         dump_rd(7'(a), d);
         checks++;
         if (d !== 8'hFF) begin
            failures++; $display("FAIL eral[%0d]: got %h required ff", a, d);
         end
      end
      do_write(7'h10, 8'h77);
      dump_rd(7'h10, d);
      checks++;
      if (d !== 8'h77) begin
         failures++; $display("FAIL write_10: got %h required 77", d);
      end
      cmd(OP_ERASE, 7'h10);
      cs_end();
      dump_rd(7'h10, d);
      checks++;
      if (d !== 8'hFF) begin
         failures++; $display("FAIL erase_10: got %h required ff", d);
      end
   endtask

   task automatic test_abort();
      logic [7:0] d;
      cmd(OP_WRITE, 7'h20);
      send_bits(16'h0005, 4);
      cs_end();
      dump_rd(7'h20, d);
      checks++;
      if (d !== 8'hFF) begin
         failures++; $display("FAIL abort_20: got %h required ff", d);
      end
      do_write(7'h20, 8'h55);
      dump_rd(7'h20, d);
      checks++;
      if (d !== 8'h55) begin
         failures++; $display("FAIL after_abort_20: got %h required 55", d);
      end
   endtask

   task automatic test_read_wrap();
      logic [16:0] got;
      do_write(7'h7F, 8'h11);
      do_write(7'h00, 8'h22);
      read_stream(7'h7F, 16, got);
      cs_end();
      checks++;
      if (got !== 17'h01122) begin
         failures++; $display("FAIL read_wrap: got %h required 01122", got);
      end
   endtask

   task automatic test_ewds();
      logic [7:0] d;
      do_ext(EXT_EWDS);
      do_write(7'h30, 8'h99);
      dump_rd(7'h30, d);
      checks++;
      if (d !== 8'hFF) begin
         failures++; $display("FAIL ewds_30: got %h required ff", d);
      end
   endtask

   initial begin
      test_reset();
      test_write_disabled();
      test_write_enabled();
      test_read();
      test_bulk();
      test_abort();
      test_read_wrap();
      test_ewds();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
